// File: rtl/pin_entry_bcd_feeder_pkg.sv
// Shared types and key/display codes for the PIN entry to BCD display path.
package pin_entry_bcd_feeder_pkg;

    typedef struct packed {
        logic [3:0] bcd5;
        logic [3:0] bcd4;
        logic [3:0] bcd3;
        logic [3:0] bcd2;
        logic [3:0] bcd1;
        logic [3:0] bcd0;
    } bcdPac_t;

    localparam int NUM_SLOTS = 6;

    localparam logic [3:0] KEY_BKSP  = 4'hC;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] BCD_DASH  = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        SUBMIT
    } pin_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/pin_entry_bcd_feeder_timer_down.sv
// Loadable down-counter that saturates at zero; zero reflects the registered count.
module timer_down #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pin_entry_bcd_feeder.sv
// Keypad-to-display PIN entry: buffers digits, masks them, and submits a full PIN
// to the lock logic with a one-cycle pulse.
module pin_entry_bcd_feeder
    import pin_entry_bcd_feeder_pkg::*;
#(
    parameter int PIN_LEN        = 6,
    parameter int MASK_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    output logic                 display_en,
    output bcdPac_t              bcd_packet,
    output logic [PIN_LEN*4-1:0] pin_out,
    output logic                 pin_valid,
    output logic [2:0]           digit_count
);

    localparam int MW = $clog2(MASK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Timers are loaded with N-1 so the registered zero flag goes high exactly N cycles after the load.
    localparam logic [MW-1:0] MASK_RELOAD = MW'(MASK_CYCLES - 1);
    localparam logic [TW-1:0] TMO_RELOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    PIN_LEN_C   = 3'(PIN_LEN);
    localparam logic [PIN_LEN-1:0][3:0] BUF_BLANK = {PIN_LEN{BCD_BLANK}};

    pin_state_t                state_q, state_d;
    logic [PIN_LEN-1:0][3:0]   buf_q, buf_d;
    logic [2:0]                count_q, count_d;
    logic                      display_en_q, display_en_d;
    logic                      pin_valid_q, pin_valid_d;
    logic [PIN_LEN*4-1:0]      pin_out_q, pin_out_d;
    bcdPac_t                   bcd_packet_q, bcd_packet_d;
    logic [NUM_SLOTS-1:0][3:0] slots;

    logic          mask_load, mask_zero, mask_show_d;
    logic [MW-1:0] mask_val;
    logic          tmo_load, tmo_zero;

    timer_down #(.W(MW)) u_mask_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (mask_load),
        .load_val (mask_val),
        .zero     (mask_zero)
    );

    timer_down #(.W(TW)) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (TMO_RELOAD),
        .zero     (tmo_zero)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        count_d     = count_q;
        mask_load   = 1'b0;
        mask_val    = MASK_RELOAD;
        mask_show_d = !mask_zero;
        tmo_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    state_d     = ENTRY;
                    buf_d       = {buf_q[PIN_LEN-2:0], key_code};
                    count_d     = 3'd1;
                    mask_load   = 1'b1;
                    mask_show_d = 1'b1;
                    tmo_load    = 1'b1;
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    tmo_load = 1'b1;
                    if (is_digit(key_code)) begin
                        if (count_q < PIN_LEN_C) begin
                            buf_d       = {buf_q[PIN_LEN-2:0], key_code};
                            count_d     = count_q + 3'd1;
                            mask_load   = 1'b1;
                            mask_show_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_BKSP: begin
                                if (count_q != 3'd0) begin
                                    buf_d       = {BCD_BLANK, buf_q[PIN_LEN-1:1]};
                                    count_d     = count_q - 3'd1;
                                    mask_load   = 1'b1;
                                    mask_val    = '0;
                                    mask_show_d = 1'b0;
                                end
                            end
                            KEY_CLEAR: begin
                                buf_d   = BUF_BLANK;
                                count_d = 3'd0;
                            end
                            KEY_ENTER: begin
                                if (count_q == PIN_LEN_C) begin
                                    state_d = SUBMIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (tmo_zero) begin
                    state_d = IDLE;
                    buf_d   = BUF_BLANK;
                    count_d = 3'd0;
                end
            end
            SUBMIT: begin
                state_d = IDLE;
                buf_d   = BUF_BLANK;
                count_d = 3'd0;
            end
            default: begin
                state_d = IDLE;
                buf_d   = BUF_BLANK;
                count_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        display_en_d = (state_d == ENTRY);
        pin_valid_d  = (state_d == SUBMIT);
        pin_out_d    = (state_d == SUBMIT) ? buf_q : pin_out_q;
        slots        = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slots[k] = BCD_BLANK;
            if (k < PIN_LEN && 3'(k) < count_d) begin
                slots[k] = (k == 0 && mask_show_d) ? buf_d[0] : BCD_DASH;
            end
        end
        bcd_packet_d = bcdPac_t'(slots);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= BUF_BLANK;
            count_q      <= 3'd0;
            display_en_q <= 1'b0;
            pin_valid_q  <= 1'b0;
            pin_out_q    <= '0;
            bcd_packet_q <= bcdPac_t'({NUM_SLOTS{BCD_BLANK}});
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            display_en_q <= display_en_d;
            pin_valid_q  <= pin_valid_d;
            pin_out_q    <= pin_out_d;
            bcd_packet_q <= bcd_packet_d;
        end
    end

    assign display_en  = display_en_q;
    assign pin_valid   = pin_valid_q;
    assign pin_out     = pin_out_q;
    assign bcd_packet  = bcd_packet_q;
    assign digit_count = count_q;

endmodule
